// File: rtl/wb_regfile_stage_pkg.sv
// Shared pipeline constants for the writeback/register-file slice.
// The ID/EX/MEM barriers and the forwarding unit import the same widths.
package wb_regfile_stage_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int INDEX_W  = 5;
  localparam int CNT_W    = 32;

  localparam logic [INDEX_W-1:0] REG_ZERO = '0;

  function automatic logic isZeroReg(input logic [INDEX_W-1:0] idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB barrier outputs as seen by the writeback stage, plus the selected
// writeback value that goes back out to the forwarding network.
interface wb_regfile_stage_if;
  import wb_regfile_stage_pkg::*;

  logic [XLEN-1:0]    wbMemoryData;
  logic [XLEN-1:0]    wbExecutionData;
  logic [INDEX_W-1:0] wbWriteRegisterIndex;
  logic               wbMemToReg;
  logic               wbRegWrite;
  logic [XLEN-1:0]    wbWriteData;

  modport master (
    output wbMemoryData, wbExecutionData, wbWriteRegisterIndex, wbMemToReg, wbRegWrite,
    input  wbWriteData
  );

  modport slave (
    input  wbMemoryData, wbExecutionData, wbWriteRegisterIndex, wbMemToReg, wbRegWrite,
    output wbWriteData
  );

endinterface

// File: rtl/wb_regfile_stage_regfile_array.sv
// Architectural integer register storage: one write port, two combinational
// reads and one registered debug read; x0 always reads as zero.
module regfile_array
  import wb_regfile_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [INDEX_W-1:0] wIdx,
  input  logic [XLEN-1:0]    wData,
  input  logic [INDEX_W-1:0] rdIdxA,
  output logic [XLEN-1:0]    rdDataA,
  input  logic [INDEX_W-1:0] rdIdxB,
  output logic [XLEN-1:0]    rdDataB,
  input  logic [INDEX_W-1:0] dbgIdx,
  output logic [XLEN-1:0]    dbgData
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Debug read samples the pre-edge contents, so a colliding write is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      dbgData <= '0;
    end else begin
      if (we && !isZeroReg(wIdx)) regs[wIdx] <= wData;
      dbgData <= isZeroReg(dbgIdx) ? '0 : regs[dbgIdx];
    end
  end

  assign rdDataA = isZeroReg(rdIdxA) ? '0 : regs[rdIdxA];
  assign rdDataB = isZeroReg(rdIdxB) ? '0 : regs[rdIdxB];

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects the writeback value, commits it to the register
// file, and serves the decode read ports with same-cycle write-first bypass.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
#(
  parameter int CNT_W = wb_regfile_stage_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  wb_regfile_stage_if.slave  wbBus,
  input  logic [INDEX_W-1:0] rs1Index,
  input  logic [INDEX_W-1:0] rs2Index,
  output logic [XLEN-1:0]    rs1Data,
  output logic [XLEN-1:0]    rs2Data,
  input  logic [INDEX_W-1:0] dbgIndex,
  output logic [XLEN-1:0]    dbgData,
  output logic [CNT_W-1:0]   writeCount,
  output logic [INDEX_W-1:0] lastWriteIndex
);

  logic [XLEN-1:0] writeData;
  logic [XLEN-1:0] arrayRs1;
  logic [XLEN-1:0] arrayRs2;
  logic            commit;

  assign writeData         = wbBus.wbMemToReg ? wbBus.wbMemoryData : wbBus.wbExecutionData;
  assign wbBus.wbWriteData = writeData;

  // wbRegWrite gates first so an X index with writes disabled cannot commit.
  assign commit = wbBus.wbRegWrite && !isZeroReg(wbBus.wbWriteRegisterIndex);

  regfile_array uArray (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .wIdx    (wbBus.wbWriteRegisterIndex),
    .wData   (writeData),
    .rdIdxA  (rs1Index),
    .rdDataA (arrayRs1),
    .rdIdxB  (rs2Index),
    .rdDataB (arrayRs2),
    .dbgIdx  (dbgIndex),
    .dbgData (dbgData)
  );

  always_comb begin
    rs1Data = arrayRs1;
    rs2Data = arrayRs2;
    if (!isZeroReg(rs1Index) && commit && rs1Index == wbBus.wbWriteRegisterIndex)
      rs1Data = writeData;
    if (!isZeroReg(rs2Index) && commit && rs2Index == wbBus.wbWriteRegisterIndex)
      rs2Data = writeData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeCount     <= '0;
      lastWriteIndex <= '0;
    end else if (commit) begin
      writeCount     <= writeCount + CNT_W'(1);
      lastWriteIndex <= wbBus.wbWriteRegisterIndex;
    end
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed and random checks of the writeback stage against an array model
// of the architectural register file.
module tb_wb_regfile_stage;
  import wb_regfile_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_stage_if bus ();
  wb_regfile_stage_if bus2 ();

  logic [4:0]  rs1Index, rs2Index, dbgIndex;
  logic [31:0] rs1Data, rs2Data, dbgData, writeCount;
  logic [4:0]  lastWriteIndex;

  logic [4:0]  rs1Index2, rs2Index2, dbgIndex2;
  logic [31:0] rs1Data2, rs2Data2, dbgData2;
  logic [3:0]  writeCount2;
  logic [4:0]  lastWriteIndex2;

  wb_regfile_stage dut (
    .clk(clk), .rst(rst), .wbBus(bus),
    .rs1Index(rs1Index), .rs2Index(rs2Index), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .dbgIndex(dbgIndex), .dbgData(dbgData),
    .writeCount(writeCount), .lastWriteIndex(lastWriteIndex)
  );

  wb_regfile_stage #(.CNT_W(4)) dutNarrow (
    .clk(clk), .rst(rst), .wbBus(bus2),
    .rs1Index(rs1Index2), .rs2Index(rs2Index2), .rs1Data(rs1Data2), .rs2Data(rs2Data2),
    .dbgIndex(dbgIndex2), .dbgData(dbgData2),
    .writeCount(writeCount2), .lastWriteIndex(lastWriteIndex2)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] model [32];
  logic [31:0] modelCount;
  logic [4:0]  modelLast;

  logic        regWrite, memToReg, xMode;
  logic [4:0]  wIdx;
  logic [31:0] memData, exeData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    modelCount = 32'h0;
    modelLast  = 5'd0;
  endtask

  function automatic logic [31:0] expectRead(input logic [4:0] idx, input logic doCommit,
                                             input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (doCommit && idx == wIdx) return wd;
    return model[idx];
  endfunction

  // Apply the staged inputs, check combinational outputs, take one edge,
  // then check the registered outputs against the updated model.
  task automatic step();
    logic [31:0] wd, expDbg;
    logic        doCommit;
    bus.wbRegWrite = regWrite;
    bus.wbMemToReg = xMode ? 1'bx : memToReg;
    bus.wbWriteRegisterIndex = xMode ? 5'bx : wIdx;
    bus.wbMemoryData = xMode ? 32'bx : memData;
    bus.wbExecutionData = xMode ? 32'bx : exeData;
    #1;
    wd = memToReg ? memData : exeData;
    doCommit = !xMode && regWrite && (wIdx != 5'd0);
    if (!xMode) check("wbWriteData", bus.wbWriteData, wd);
    check("rs1Data", rs1Data, expectRead(rs1Index, doCommit, wd));
    check("rs2Data", rs2Data, expectRead(rs2Index, doCommit, wd));
    @(posedge clk);
    expDbg = (dbgIndex == 5'd0) ? 32'h0 : model[dbgIndex];
    if (doCommit) begin
      model[wIdx] = wd;
      modelCount  = modelCount + 32'd1;
      modelLast   = wIdx;
    end
    #1;
    check("dbgData", dbgData, expDbg);
    check("writeCount", writeCount, modelCount);
    check("lastWriteIndex", {27'h0, lastWriteIndex}, {27'h0, modelLast});
  endtask

  task automatic stage(input logic rw, input logic m2r, input logic [4:0] idx,
                       input logic [31:0] mem, input logic [31:0] exe,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    regWrite = rw; memToReg = m2r; wIdx = idx; memData = mem; exeData = exe;
    rs1Index = r1; rs2Index = r2; dbgIndex = dbg;
  endtask

  initial begin
    xMode = 1'b0;
    rst = 1'b0;
    modelReset();
    stage(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    bus.wbRegWrite = 1'b0; bus.wbMemToReg = 1'b0; bus.wbWriteRegisterIndex = 5'd0;
    bus.wbMemoryData = 32'h0; bus.wbExecutionData = 32'h0;
    bus2.wbRegWrite = 1'b0; bus2.wbMemToReg = 1'b0; bus2.wbWriteRegisterIndex = 5'd1;
    bus2.wbMemoryData = 32'h0; bus2.wbExecutionData = 32'h1;
    rs1Index2 = 5'd1; rs2Index2 = 5'd0; dbgIndex2 = 5'd1;

    // Reset state over every index
    for (int i = 0; i < 32; i++) begin
      rs1Index = 5'(i); rs2Index = 5'(31 - i); dbgIndex = 5'(i);
      @(posedge clk); #1;
      check("rstRs1", rs1Data, 32'h0);
      check("rstRs2", rs2Data, 32'h0);
      check("rstDbg", dbgData, 32'h0);
    end
    check("rstCount", writeCount, 32'h0);
    check("rstLast", {27'h0, lastWriteIndex}, 32'h0);
    rst = 1'b1;

    // Directed cases
    stage(1'b1, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5); step();
    stage(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5); step();
    check("x5", rs1Data, 32'hDEADBEEF);
    stage(1'b1, 1'b1, 5'd7, 32'h12345678, 32'hFFFFFFFF, 5'd7, 5'd5, 5'd7); step();
    stage(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 5'd7); step();
    check("x7", rs1Data, 32'h12345678);
    stage(1'b1, 1'b0, 5'd0, 32'h0, 32'hAAAA5555, 5'd0, 5'd0, 5'd0); step();
    check("x0Count", writeCount, 32'd2);
    check("x0Last", {27'h0, lastWriteIndex}, 32'd7);
    stage(1'b1, 1'b0, 5'd9, 32'h0, 32'h0000CAFE, 5'd9, 5'd9, 5'd9); step();
    check("bypassDbgOld", dbgData, 32'h0);
    stage(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9); step();
    check("x9Dbg", dbgData, 32'h0000CAFE);

    // X on inputs while writes are disabled
    xMode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stage(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd9, 5'd7); step();
    end
    xMode = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [4:0] idx;
      idx = 5'($urandom_range(0, 31));
      stage($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), idx, $urandom(), $urandom(),
            ($urandom_range(0, 2) == 0) ? idx : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? idx : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      step();
    end

    // Asynchronous reset between edges
    stage(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7, 5'd9);
    bus.wbRegWrite = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    modelReset();
    check("arstRs1", rs1Data, 32'h0);
    check("arstRs2", rs2Data, 32'h0);
    check("arstDbg", dbgData, 32'h0);
    check("arstCount", writeCount, 32'h0);
    check("arstLast", {27'h0, lastWriteIndex}, 32'h0);
    bus.wbRegWrite = 1'b1; bus.wbWriteRegisterIndex = 5'd3;
    bus.wbMemToReg = 1'b0; bus.wbExecutionData = 32'h0BADF00D;
    @(posedge clk); #1;
    bus.wbRegWrite = 1'b0;
    rs1Index = 5'd3;
    #1;
    check("rstDropsCommit", rs1Data, 32'h0);
    check("rstCountHeld", writeCount, 32'h0);
    rst = 1'b1;
    stage(1'b1, 1'b0, 5'd3, 32'h0, 32'h13572468, 5'd3, 5'd1, 5'd3); step();
    stage(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0); step();

    // Counter wrap on the narrow-counter instance
    bus2.wbRegWrite = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      check("narrowCount", {28'h0, writeCount2}, 32'((k + 1) % 16));
    end
    bus2.wbRegWrite = 1'b0;
    check("narrowLast", {27'h0, lastWriteIndex2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
Consumer end of the MEM/WB pipeline register: takes the wb-side signals, selects the writeback value, and commits it into the architectural integer register file. Provides two combinational decode read ports with same-cycle write-first bypass. Also provides a registered debug read port and a committed-write counter for the test harness. Sits between the MEM/WB barrier outputs and the ID stage.

Parameters:
XLEN, 32, data width of registers and writeback values
NUM_REGS, 32, number of architectural registers, with x0 hardwired to zero
INDEX_W, 5, register index width; must satisfy 2**INDEX_W == NUM_REGS
CNT_W, 32, width of the committed-write counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
wbMemoryData  in  XLEN  load data from the MEM/WB barrier
wbExecutionData  in  XLEN  ALU/execution result from the MEM/WB barrier
wbWriteRegisterIndex  in  INDEX_W  destination register index
wbMemToReg  in  1  1 selects wbMemoryData, 0 selects wbExecutionData
wbRegWrite  in  1  write enable
rs1Index  in  INDEX_W  decode read port 1 index
rs2Index  in  INDEX_W  decode read port 2 index
rs1Data  out  XLEN  read port 1 data (combinational)
rs2Data  out  XLEN  read port 2 data (combinational)
wbWriteData  out  XLEN  selected writeback value (combinational), also fed to forwarding
dbgIndex  in  INDEX_W  debug read index
dbgData  out  XLEN  debug read data, registered, 1-cycle latency
writeCount  out  CNT_W  number of committed non-x0 writes
lastWriteIndex  out  INDEX_W  index of the most recent committed write

Behaviour:
- wbWriteData = wbMemToReg ? wbMemoryData : wbExecutionData. This is pure combinational and is valid even when wbRegWrite=0.
- commit = wbRegWrite && (wbWriteRegisterIndex != 0).
- On a rising edge with commit=1:
  - regs[wbWriteRegisterIndex] <= wbWriteData.
  - writeCount <= writeCount+1; it wraps modulo 2**CNT_W with no saturation.
  - lastWriteIndex <= wbWriteRegisterIndex.
- With commit=0, all state holds. A write to x0 is discarded: the counter does not advance and lastWriteIndex does not change.
- Read ports (rsN = rs1 or rs2):
  - rsNIndex == 0 → 0.
  - Otherwise, if commit=1 and rsNIndex == wbWriteRegisterIndex → wbWriteData (write-first bypass, same cycle).
  - Otherwise → regs[rsNIndex].
  - The two ports are independent; both may hit the bypass in the same cycle.
- Debug port: dbgData <= value of regs[dbgIndex] as stored before this edge's write. There is no bypass on this port, so it returns the old value when it collides with a same-cycle write. dbgIndex == 0 gives 0.
- Reset (rst=0), asynchronous: all regs, dbgData, writeCount and lastWriteIndex go to 0 immediately, with no wait for clk. While rst=0, no writes occur. Reset asserted mid-operation discards any in-flight commit in that cycle.
- The first active edge after rst deasserts behaves normally.
- X on the inputs while wbRegWrite=0 must not corrupt state.

Decomposition:
- Shared package holds XLEN, NUM_REGS, INDEX_W and the constant REG_ZERO = 0. The same constants are used by the ID/EX/MEM barriers and the forwarding unit.
- One sub-module, regfile_array. It contains the 32xXLEN storage, one write port, two combinational reads plus one registered read, and the x0 masking.
- The writeback mux, bypass compare and counters live in the top level.

Test Plan:
- Reset: hold rst=0, then pulse clk → rs1Data, rs2Data, dbgData and writeCount are all 0 for every index; lastWriteIndex=0.
- Write/read: wbRegWrite=1, index=5, wbMemToReg=0, wbExecutionData=0xDEADBEEF for one edge; next cycle rs1Index=5 → 0xDEADBEEF, writeCount=1, lastWriteIndex=5.
- MemToReg select: wbMemToReg=1, wbMemoryData=0x12345678, wbExecutionData=0xFFFFFFFF, index=7 → wbWriteData=0x12345678, and regs[7] reads 0x12345678 afterwards.
- x0 discard: wbRegWrite=1, index=0, data=0xAAAA5555 → x0 still reads 0, writeCount unchanged, lastWriteIndex unchanged.
- Bypass: in the same cycle, write index=9 with 0x0000CAFE, rs1Index=9 and rs2Index=9 → both ports show 0x0000CAFE before the edge. With dbgIndex=9 in that cycle, dbgData shows the prior value, 0.
- Async reset mid-run: after several writes, drop rst between edges → every output clears without waiting for clk. A commit presented during reset is not stored. Separately, with a forced writeCount=0xFFFFFFFF, one commit wraps it to 0.
